// File: rtl/mips_wb_arbiter.sv
// Writeback scheduler sharing two register-file write ports between ALU, load and paired multiplier.
// Optional macro WB_STALL_CNT_EN adds saturating per-requester stall counters.
module mips_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              mul_valid,
  input  logic [ADDR_W-1:0] mul_reg_a,
  input  logic [ADDR_W-1:0] mul_reg_b,
  input  logic [DATA_W-1:0] mul_data_a,
  input  logic [DATA_W-1:0] mul_data_b,
  output logic              mul_ready,
  output logic [ADDR_W-1:0] write_reg,
  output logic [ADDR_W-1:0] write_reg2,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] write_data2,
  output logic              signal_reg_write,
  output logic              signal_reg_write2
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]       alu_stall_cnt,
  output logic [15:0]       mem_stall_cnt,
  output logic [15:0]       mul_stall_cnt
`endif
);

  typedef enum logic [1:0] {PTR_ALU = 2'd0, PTR_MEM = 2'd1, PTR_MUL = 2'd2} ptr_e;

  ptr_e              ptr_q, ptr_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d, write_reg2_q, write_reg2_d;
  logic [DATA_W-1:0] write_data_q, write_data_d, write_data2_q, write_data2_d;
  logic              signal_reg_write_q, signal_reg_write_d;
  logic              signal_reg_write2_q, signal_reg_write2_d;
  logic              alu_gnt, mem_gnt, mul_gnt;

  function automatic ptr_e next_ptr(input ptr_e p);
    case (p)
      PTR_ALU: return PTR_MEM;
      PTR_MEM: return PTR_MUL;
      default: return PTR_ALU;
    endcase
  endfunction

  // Visit requesters in rotating priority order, spending the two-port budget.
  always_comb begin : arb_comb
    ptr_e              order [3];
    ptr_e              slot;
    logic              c_valid, c_pair, hit_a, hit_b, ok, any_gnt;
    logic [ADDR_W-1:0] c_reg_a, c_reg_b, g_reg_a, g_reg_b;
    logic [DATA_W-1:0] c_data_a, c_data_b;
    logic [1:0]        used;

    alu_gnt             = 1'b0;
    mem_gnt             = 1'b0;
    mul_gnt             = 1'b0;
    ptr_d               = ptr_q;
    write_reg_d         = write_reg_q;
    write_reg2_d        = write_reg2_q;
    write_data_d        = write_data_q;
    write_data2_d       = write_data2_q;
    signal_reg_write_d  = 1'b0;
    signal_reg_write2_d = 1'b0;
    used                = 2'd0;
    g_reg_a             = '0;
    g_reg_b             = '0;
    any_gnt             = 1'b0;
    slot                = ptr_q;
    c_valid             = 1'b0;
    c_pair              = 1'b0;
    c_reg_a             = '0;
    c_reg_b             = '0;
    c_data_a            = '0;
    c_data_b            = '0;
    hit_a               = 1'b0;
    hit_b               = 1'b0;
    ok                  = 1'b0;
    order[0]            = ptr_q;
    order[1]            = next_ptr(ptr_q);
    order[2]            = next_ptr(order[1]);

    for (int k = 0; k < 3; k++) begin
      slot = order[k];
      case (slot)
        PTR_MEM: begin
          c_valid = mem_valid; c_pair = 1'b0;
          c_reg_a = mem_reg;   c_reg_b = mem_reg;
          c_data_a = mem_data; c_data_b = mem_data;
        end
        PTR_MUL: begin
          c_valid = mul_valid;  c_pair = 1'b1;
          c_reg_a = mul_reg_a;  c_reg_b = mul_reg_b;
          c_data_a = mul_data_a; c_data_b = mul_data_b;
        end
        default: begin
          c_valid = alu_valid; c_pair = 1'b0;
          c_reg_a = alu_reg;   c_reg_b = alu_reg;
          c_data_a = alu_data; c_data_b = alu_data;
        end
      endcase
      // Register 0 never conflicts; unused grant slots hold 0 so they never match.
      hit_a = (c_reg_a != '0) && ((c_reg_a == g_reg_a) || (c_reg_a == g_reg_b));
      hit_b = (c_reg_b != '0) && ((c_reg_b == g_reg_a) || (c_reg_b == g_reg_b));
      if (c_pair) ok = c_valid && (used == 2'd0) && !hit_a && !hit_b;
      else        ok = c_valid && (used != 2'd2) && !hit_a;

      if (ok && !rst) begin
        case (slot)
          PTR_MEM: mem_gnt = 1'b1;
          PTR_MUL: mul_gnt = 1'b1;
          default: alu_gnt = 1'b1;
        endcase
        if (!any_gnt) ptr_d = next_ptr(slot);
        any_gnt = 1'b1;
        if (c_pair) begin
          write_reg_d         = c_reg_a;
          write_data_d        = c_data_a;
          signal_reg_write_d  = (c_reg_a != '0) && (c_reg_a != c_reg_b);
          write_reg2_d        = c_reg_b;
          write_data2_d       = c_data_b;
          signal_reg_write2_d = (c_reg_b != '0);
          g_reg_a             = c_reg_a;
          g_reg_b             = c_reg_b;
          used                = 2'd2;
        end else if (used == 2'd0) begin
          write_reg_d         = c_reg_a;
          write_data_d        = c_data_a;
          signal_reg_write_d  = (c_reg_a != '0);
          g_reg_a             = c_reg_a;
          used                = 2'd1;
        end else begin
          write_reg2_d        = c_reg_a;
          write_data2_d       = c_data_a;
          signal_reg_write2_d = (c_reg_a != '0);
          g_reg_b             = c_reg_a;
          used                = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q               <= PTR_ALU;
      write_reg_q         <= '0;
      write_reg2_q        <= '0;
      write_data_q        <= '0;
      write_data2_q       <= '0;
      signal_reg_write_q  <= 1'b0;
      signal_reg_write2_q <= 1'b0;
    end else begin
      ptr_q               <= ptr_d;
      write_reg_q         <= write_reg_d;
      write_reg2_q        <= write_reg2_d;
      write_data_q        <= write_data_d;
      write_data2_q       <= write_data2_d;
      signal_reg_write_q  <= signal_reg_write_d;
      signal_reg_write2_q <= signal_reg_write2_d;
    end
  end

  assign alu_ready         = alu_gnt;
  assign mem_ready         = mem_gnt;
  assign mul_ready         = mul_gnt;
  assign write_reg         = write_reg_q;
  assign write_reg2        = write_reg2_q;
  assign write_data        = write_data_q;
  assign write_data2       = write_data2_q;
  assign signal_reg_write  = signal_reg_write_q;
  assign signal_reg_write2 = signal_reg_write2_q;

`ifdef WB_STALL_CNT_EN
  logic [15:0] alu_stall_q, alu_stall_d, mem_stall_q, mem_stall_d, mul_stall_q, mul_stall_d;

  // Saturating counts of cycles a requester waited with valid raised.
  always_comb begin
    alu_stall_d = alu_stall_q;
    mem_stall_d = mem_stall_q;
    mul_stall_d = mul_stall_q;
    if (alu_valid && !alu_gnt && (alu_stall_q != 16'hFFFF)) alu_stall_d = alu_stall_q + 16'd1;
    if (mem_valid && !mem_gnt && (mem_stall_q != 16'hFFFF)) mem_stall_d = mem_stall_q + 16'd1;
    if (mul_valid && !mul_gnt && (mul_stall_q != 16'hFFFF)) mul_stall_d = mul_stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_stall_q <= '0;
      mem_stall_q <= '0;
      mul_stall_q <= '0;
    end else begin
      alu_stall_q <= alu_stall_d;
      mem_stall_q <= mem_stall_d;
      mul_stall_q <= mul_stall_d;
    end
  end

  assign alu_stall_cnt = alu_stall_q;
  assign mem_stall_cnt = mem_stall_q;
  assign mul_stall_cnt = mul_stall_q;
`endif

endmodule

// File: tb/tb_mips_wb_arbiter.sv
// Randomized self-checking bench for mips_wb_arbiter against a queue-based writeback model.
module tb_mips_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0, mem_valid = 1'b0, mul_valid = 1'b0;
  logic [AW-1:0] alu_reg = '0, mem_reg = '0, mul_reg_a = '0, mul_reg_b = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0, mul_data_a = '0, mul_data_b = '0;
  logic          alu_ready, mem_ready, mul_ready;
  logic [AW-1:0] write_reg, write_reg2;
  logic [DW-1:0] write_data, write_data2;
  logic          signal_reg_write, signal_reg_write2;
`ifdef WB_STALL_CNT_EN
  logic [15:0]   alu_stall_cnt, mem_stall_cnt, mul_stall_cnt;
`endif

  always #5 clk = ~clk;

  mips_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .mul_valid(mul_valid), .mul_reg_a(mul_reg_a), .mul_reg_b(mul_reg_b),
    .mul_data_a(mul_data_a), .mul_data_b(mul_data_b), .mul_ready(mul_ready),
    .write_reg(write_reg), .write_reg2(write_reg2),
    .write_data(write_data), .write_data2(write_data2),
    .signal_reg_write(signal_reg_write), .signal_reg_write2(signal_reg_write2)
`ifdef WB_STALL_CNT_EN
    , .alu_stall_cnt(alu_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .mul_stall_cnt(mul_stall_cnt)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Model state: requester index 0=ALU, 1=MEM, 2=MUL.
  bit            m_init = 1'b0;
  bit            m_rst_prev = 1'b1;
  int            m_ptr = 0;
  int            n_ptr = 0;
  bit            m_gnt [3];
  bit            n_p1, n_p2, n_we1, n_we2;
  logic [AW-1:0] n_r1, n_r2;
  logic [DW-1:0] n_d1, n_d2;
  bit            e_we1, e_we2, e_k1, e_k2;
  logic [AW-1:0] e_r1, e_r2;
  logic [DW-1:0] e_d1, e_d2;
  int            e_stall [3];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Grant decision for the current inputs: walk the rotating order with a two-port budget.
  task automatic modelComb();
    int            used;
    int            s;
    bit            v, pair, hit, first;
    logic [AW-1:0] ra, rb;
    logic [DW-1:0] da, db;
    logic [AW-1:0] taken [$];
    used = 0; first = 1'b1; n_ptr = m_ptr;
    n_p1 = 0; n_p2 = 0; n_we1 = 0; n_we2 = 0;
    n_r1 = '0; n_r2 = '0; n_d1 = '0; n_d2 = '0;
    for (int i = 0; i < 3; i++) m_gnt[i] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s = (m_ptr + k) % 3;
      pair = (s == 2);
      if (s == 0)      begin v = alu_valid; ra = alu_reg;   rb = alu_reg;   da = alu_data;   db = alu_data;   end
      else if (s == 1) begin v = mem_valid; ra = mem_reg;   rb = mem_reg;   da = mem_data;   db = mem_data;   end
      else             begin v = mul_valid; ra = mul_reg_a; rb = mul_reg_b; da = mul_data_a; db = mul_data_b; end
      hit = 1'b0;
      foreach (taken[j]) begin
        if (ra != 0 && taken[j] == ra) hit = 1'b1;
        if (pair && rb != 0 && taken[j] == rb) hit = 1'b1;
      end
      if (v && !rst && !hit && (pair ? used == 0 : used < 2)) begin
        m_gnt[s] = 1'b1;
        if (first) n_ptr = (s + 1) % 3;
        first = 1'b0;
        if (pair) begin
          n_p1 = 1; n_r1 = ra; n_d1 = da; n_we1 = (ra != 0) && (ra != rb);
          n_p2 = 1; n_r2 = rb; n_d2 = db; n_we2 = (rb != 0);
          used = 2;
          taken.push_back(ra);
          taken.push_back(rb);
        end else if (used == 0) begin
          n_p1 = 1; n_r1 = ra; n_d1 = da; n_we1 = (ra != 0);
          used = 1;
          taken.push_back(ra);
        end else begin
          n_p2 = 1; n_r2 = ra; n_d2 = da; n_we2 = (ra != 0);
          used = 2;
          taken.push_back(ra);
        end
      end
    end
    m_rst_prev = rst;
  endtask

  // Register-file side of the model, advanced once per rising edge.
  task automatic modelClock();
    if (m_rst_prev) begin
      m_ptr = 0;
      e_we1 = 0; e_we2 = 0; e_r1 = '0; e_r2 = '0; e_d1 = '0; e_d2 = '0;
      e_k1 = 1; e_k2 = 1;
      for (int i = 0; i < 3; i++) e_stall[i] = 0;
      m_init = 1'b1;
    end else begin
      if (alu_valid && !m_gnt[0] && e_stall[0] < 65535) e_stall[0]++;
      if (mem_valid && !m_gnt[1] && e_stall[1] < 65535) e_stall[1]++;
      if (mul_valid && !m_gnt[2] && e_stall[2] < 65535) e_stall[2]++;
      m_ptr = n_ptr;
      e_we1 = n_we1;
      e_we2 = n_we2;
      // A granted port with its enable dropped leaves index/data unconstrained.
      if (n_p1) begin e_r1 = n_r1; e_d1 = n_d1; e_k1 = n_we1; end
      if (n_p2) begin e_r2 = n_r2; e_d2 = n_d2; e_k2 = n_we2; end
    end
  endtask

  task automatic applyStimulus(input bit r,
                               input bit av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                               input bit mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                               input bit uv, input logic [AW-1:0] ua, input logic [AW-1:0] ub,
                               input logic [DW-1:0] uda, input logic [DW-1:0] udb);
    @(posedge clk);
    modelClock();
    #1;
    rst = r;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
    mul_valid = uv; mul_reg_a = ua; mul_reg_b = ub; mul_data_a = uda; mul_data_b = udb;
    modelComb();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, '0, '0, 0, '0, '0, 0, '0, '0, '0, '0);
  endtask

  task automatic resetCycle();
    applyStimulus(1, 0, '0, '0, 0, '0, '0, 0, '0, '0, '0, '0);
  endtask

  // Every cycle, compare the DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (m_init) begin
      checkOutput("alu_ready", 32'(alu_ready), 32'(m_gnt[0]));
      checkOutput("mem_ready", 32'(mem_ready), 32'(m_gnt[1]));
      checkOutput("mul_ready", 32'(mul_ready), 32'(m_gnt[2]));
      checkOutput("signal_reg_write", 32'(signal_reg_write), 32'(e_we1));
      checkOutput("signal_reg_write2", 32'(signal_reg_write2), 32'(e_we2));
      if (e_k1) begin
        checkOutput("write_reg", 32'(write_reg), 32'(e_r1));
        checkOutput("write_data", write_data, e_d1);
      end
      if (e_k2) begin
        checkOutput("write_reg2", 32'(write_reg2), 32'(e_r2));
        checkOutput("write_data2", write_data2, e_d2);
      end
`ifdef WB_STALL_CNT_EN
      checkOutput("alu_stall_cnt", 32'(alu_stall_cnt), 32'(e_stall[0]));
      checkOutput("mem_stall_cnt", 32'(mem_stall_cnt), 32'(e_stall[1]));
      checkOutput("mul_stall_cnt", 32'(mul_stall_cnt), 32'(e_stall[2]));
`endif
    end
  end

  initial begin
    bit            nr, av, mv, uv;
    logic [AW-1:0] ar, mr, ua, ub;
    logic [DW-1:0] ad, md, uda, udb;

    resetCycle();
    resetCycle();

    // Single ALU write lands on port 1.
    applyStimulus(0, 1, 5'd3, 32'hAAAA5555, 0, '0, '0, 0, '0, '0, '0, '0);
    @(negedge clk); checkOutput("t1 alu_ready", 32'(alu_ready), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("t1 we1", 32'(signal_reg_write), 32'd1);
    checkOutput("t1 reg1", 32'(write_reg), 32'd3);
    checkOutput("t1 data1", write_data, 32'hAAAA5555);
    checkOutput("t1 we2", 32'(signal_reg_write2), 32'd0);

    // ALU+MEM share the ports; pointer then favours MEM on a conflict.
    resetCycle();
    applyStimulus(0, 1, 5'd4, 32'h11111111, 1, 5'd5, 32'h22222222, 0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("t2 alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("t2 mem_ready", 32'(mem_ready), 32'd1);
    applyStimulus(0, 1, 5'd1, 32'h33, 1, 5'd1, 32'h44, 0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("t2 reg1", 32'(write_reg), 32'd4);
    checkOutput("t2 data1", write_data, 32'h11111111);
    checkOutput("t2 reg2", 32'(write_reg2), 32'd5);
    checkOutput("t2 data2", write_data2, 32'h22222222);
    checkOutput("t2 ptr mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t2 ptr alu_ready", 32'(alu_ready), 32'd0);
    applyStimulus(0, 1, 5'd1, 32'h33, 0, '0, '0, 0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("t2 late alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("t2 mem on port1", write_data, 32'h44);

    // MUL waits while singles take the ports, then gets both.
    resetCycle();
    applyStimulus(0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2, 1, 5'd6, 5'd7, 32'hA6, 32'hA7);
    @(negedge clk);
    checkOutput("t3 alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("t3 mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("t3 mul_ready", 32'(mul_ready), 32'd0);
    applyStimulus(0, 0, '0, '0, 0, '0, '0, 1, 5'd6, 5'd7, 32'hA6, 32'hA7);
    @(negedge clk); checkOutput("t3 mul_ready2", 32'(mul_ready), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("t3 reg1", 32'(write_reg), 32'd6);
    checkOutput("t3 reg2", 32'(write_reg2), 32'd7);
    checkOutput("t3 data2", write_data2, 32'hA7);
    checkOutput("t3 we1", 32'(signal_reg_write), 32'd1);
    checkOutput("t3 we2", 32'(signal_reg_write2), 32'd1);

    // Same-destination conflict, then reset while MEM is pending.
    resetCycle();
    applyStimulus(0, 1, 5'd9, 32'h99, 1, 5'd9, 32'h98, 0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("t4 alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("t4 mem_ready", 32'(mem_ready), 32'd0);
    applyStimulus(0, 0, '0, '0, 1, 5'd9, 32'h98, 0, '0, '0, '0, '0);
    @(negedge clk); checkOutput("t4 mem_ready2", 32'(mem_ready), 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("t4 reg1", 32'(write_reg), 32'd9);
    checkOutput("t4 data1", write_data, 32'h98);
    checkOutput("t4 we2", 32'(signal_reg_write2), 32'd0);
    applyStimulus(1, 0, '0, '0, 1, 5'd12, 32'hC, 0, '0, '0, '0, '0);
    @(negedge clk); checkOutput("t6 mem_ready rst", 32'(mem_ready), 32'd0);
    applyStimulus(0, 0, '0, '0, 1, 5'd12, 32'hC, 0, '0, '0, '0, '0);
    @(negedge clk);
    checkOutput("t6 we1", 32'(signal_reg_write), 32'd0);
    checkOutput("t6 reg1", 32'(write_reg), 32'd0);
    checkOutput("t6 data1", write_data, 32'd0);
    checkOutput("t6 mem_ready post", 32'(mem_ready), 32'd1);
`ifdef WB_STALL_CNT_EN
    checkOutput("t6 mem_stall_cnt", 32'(mem_stall_cnt), 32'd0);
`endif

    // Register 0 consumes a grant but never enables the port.
    resetCycle();
    applyStimulus(0, 1, 5'd0, 32'h1234, 0, '0, '0, 0, '0, '0, '0, '0);
    @(negedge clk); checkOutput("t5 alu_ready", 32'(alu_ready), 32'd1);
    idleCycle();
    @(negedge clk); checkOutput("t5 we1", 32'(signal_reg_write), 32'd0);

    // Randomized traffic; requesters hold until granted.
    for (int c = 0; c < 2000; c++) begin
      nr = ($urandom_range(0, 59) == 0);
      av = alu_valid; ar = alu_reg; ad = alu_data;
      mv = mem_valid; mr = mem_reg; md = mem_data;
      uv = mul_valid; ua = mul_reg_a; ub = mul_reg_b; uda = mul_data_a; udb = mul_data_b;
      if (!alu_valid || m_gnt[0]) begin
        av = ($urandom_range(0, 99) < 60); ar = AW'($urandom_range(0, 7)); ad = $urandom;
      end
      if (!mem_valid || m_gnt[1]) begin
        mv = ($urandom_range(0, 99) < 60); mr = AW'($urandom_range(0, 7)); md = $urandom;
      end
      if (!mul_valid || m_gnt[2]) begin
        uv = ($urandom_range(0, 99) < 45); ua = AW'($urandom_range(0, 7));
        ub = ($urandom_range(0, 5) == 0) ? ua : AW'($urandom_range(0, 7));
        uda = $urandom; udb = $urandom;
      end
      applyStimulus(nr, av, ar, ad, mv, mr, md, uv, ua, ub, uda, udb);
    end
    idleCycle();
    idleCycle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mips_wb_arbiter.md
Name: mips_wb_arbiter

Overview:
Writeback scheduler that shares the register file's two write ports between three producers. The producers are the ALU (one write), the load unit (one write) and the multiplier (a paired two-register write that needs both ports in the same cycle). It sits between the execute/memory stages and the register file. It arbitrates round-robin under a port budget, resolves same-destination conflicts and drives registered port-1/port-2 write controls.

Parameters:
DATA_W, 32, data width of every write payload
ADDR_W, 5, register index width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
alu_valid  in  1  ALU write request
alu_reg  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU write data
alu_ready  out  1  ALU request granted this cycle
mem_valid  in  1  load write request
mem_reg  in  ADDR_W  load destination register
mem_data  in  DATA_W  load write data
mem_ready  out  1  load request granted this cycle
mul_valid  in  1  multiplier paired write request
mul_reg_a  in  ADDR_W  first destination register
mul_reg_b  in  ADDR_W  second destination register
mul_data_a  in  DATA_W  data for mul_reg_a
mul_data_b  in  DATA_W  data for mul_reg_b
mul_ready  out  1  paired request granted this cycle
write_reg, write_reg2  out  ADDR_W  register-file port 1/2 index (registered)
write_data, write_data2  out  DATA_W  register-file port 1/2 data (registered)
signal_reg_write, signal_reg_write2  out  1  register-file port 1/2 enable (registered)

Behaviour:
- Reset: every registered output is 0. The round-robin pointer is set to ALU.
- Readies are combinational from the current requests and the pointer. If rst is high, all readies are 0.
- Handshake: a transfer happens when valid && ready. A requester holds valid and its payload stable until ready. There is no retraction rule; the bench must never drop valid without ready.
- Priority order starts at the pointer: ALU -> MEM -> MUL -> ALU.
- Port budget is 2 per cycle. Requesters are visited in priority order.
  - A single-write requester is granted if at least 1 port is free.
  - MUL is granted only if 2 ports are free. Otherwise it is skipped; later single requesters may still be granted.
- Port assignment:
  - The first single grant goes to port 1, the second to port 2.
  - A MUL grant puts reg_a on port 1 and reg_b on port 2.
- Same-destination conflict: a request whose nonzero destination matches a register already granted this cycle is not granted and waits.
  - For MUL this covers either of its registers.
  - mul_reg_a == mul_reg_b (nonzero) is granted. Only port 2 is enabled, so the b data wins.
- Register 0: the request is granted (ready=1) and consumes a port, but that port's enable is registered as 0. Register 0 never conflicts.
- Latency: granted payloads appear on the port outputs at the next posedge. The register file commits them one posedge later.
  - A port with no grant registers enable=0. Its index and data hold their previous values.
- Pointer update: when any grant occurs, the pointer moves to the requester after the highest-priority granted one. With no grant, the pointer holds.
- Fairness: MUL is guaranteed both ports whenever it is first in priority order, so no requester starves beyond 2 granting cycles.
- Reset mid-operation: pending requests are ignored while rst is high. The next cycle's outputs are 0 and the pointer returns to ALU.

Optional Feature:
Macro: WB_STALL_CNT_EN.
- Defined: adds three 16-bit outputs, alu_stall_cnt, mem_stall_cnt and mul_stall_cnt.
  - Each counts cycles with valid && !ready for its requester.
  - Counts saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and counters do not exist. Arbitration is identical either way.

Test Plan:
- ALU only, valid with reg=3, data=0xAAAA5555, after reset -> alu_ready=1 same cycle. Next cycle signal_reg_write=1, write_reg=3, write_data=0xAAAA5555, signal_reg_write2=0.
- ALU reg=4 and MEM reg=5 both valid, pointer=ALU -> both ready. Port1=(4, alu_data), port2=(5, mem_data). Pointer becomes MEM.
- All three valid (regs 1, 2 and 6/7), pointer=ALU -> cycle 1 grants ALU+MEM with MUL stalled. Cycle 2 grants MUL: port1=6, port2=7, both enables=1.
- ALU reg=9 and MEM reg=9, pointer=ALU -> only ALU granted. MEM is granted the next cycle on port 1.
- ALU reg=0, data=0x1234 -> alu_ready=1. Next cycle signal_reg_write=0.
- rst asserted while MEM valid -> mem_ready=0. Next cycle all outputs are 0. Under WB_STALL_CNT_EN, mem_stall_cnt=0 after reset, then increments by 1 per stalled cycle.
